ex_unit: RTL and testbench

EX_UNIT -- requirements
Module: ex_unit

---
 rtl/ex_unit_if.sv | 25 ++
 rtl/ex_unit.sv | 235 +++++++++++++++++++++++
 tb/tb_ex_unit.sv | 261 ++++++++++++++++++++++++++
 3 files changed

// File: rtl/ex_unit_if.sv
// Bundle of the ID/EX operand, control and result signals seen by the execute stage.
// The master modport is the pipeline side; the slave modport is the execute unit.
interface ex_unit_if;
    logic [7:0]  aluop_i;
    logic [2:0]  alusel_i;
    logic [31:0] reg1_i;
    logic [31:0] reg2_i;
    logic [4:0]  wd_i;
    logic        wreg_i;
    logic        flush_i;
    logic [4:0]  wd_o;
    logic        wreg_o;
    logic [31:0] wdata_o;
    logic        stallreq_o;

    modport master (
        output aluop_i, alusel_i, reg1_i, reg2_i, wd_i, wreg_i, flush_i,
        input  wd_o, wreg_o, wdata_o, stallreq_o
    );

    modport slave (
        input  aluop_i, alusel_i, reg1_i, reg2_i, wd_i, wreg_i, flush_i,
        output wd_o, wreg_o, wdata_o, stallreq_o
    );
endinterface

// File: rtl/ex_unit.sv
// Execute stage: single-cycle logic/shift/arith/mul plus a 32-step restoring divider
// that stalls the front of the pipeline while it iterates.
module ex_unit (
    input  logic     clk,
    input  logic     resetn,
    ex_unit_if.slave ex
);

    localparam logic [2:0] SEL_NOP   = 3'b000;
    localparam logic [2:0] SEL_LOGIC = 3'b001;
    localparam logic [2:0] SEL_SHIFT = 3'b010;
    localparam logic [2:0] SEL_ARITH = 3'b011;
    localparam logic [2:0] SEL_MUL   = 3'b100;
    localparam logic [2:0] SEL_DIV   = 3'b101;

    localparam logic [7:0] OP_AND  = 8'h24;
    localparam logic [7:0] OP_OR   = 8'h25;
    localparam logic [7:0] OP_XOR  = 8'h26;
    localparam logic [7:0] OP_NOR  = 8'h27;
    localparam logic [7:0] OP_SLL  = 8'h7C;
    localparam logic [7:0] OP_SRL  = 8'h02;
    localparam logic [7:0] OP_SRA  = 8'h03;
    localparam logic [7:0] OP_ADD  = 8'h21;
    localparam logic [7:0] OP_SUB  = 8'h23;
    localparam logic [7:0] OP_SLT  = 8'h2A;
    localparam logic [7:0] OP_SLTU = 8'h2B;
    localparam logic [7:0] OP_MUL  = 8'h18;
    localparam logic [7:0] OP_DIV  = 8'h1A;
    localparam logic [7:0] OP_DIVU = 8'h1B;
    localparam logic [7:0] OP_REM  = 8'h1C;
    localparam logic [7:0] OP_REMU = 8'h1D;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUSY = 2'd1,
        DONE = 2'd2
    } div_state_t;

    div_state_t  state_q, state_d;
    logic [4:0]  count_q;
    logic [31:0] divisor_q;
    logic [31:0] quo_q;
    logic [31:0] rem_q;
    logic [31:0] result_q;
    logic        want_rem_q;
    logic        neg_quo_q;
    logic        neg_rem_q;

    logic        is_div_op;
    logic        div_req;
    logic        signed_op;
    logic        a_neg;
    logic        b_neg;
    logic [31:0] a_abs;
    logic [31:0] b_abs;
    logic        want_rem;
    logic        div_by_zero;

    logic [32:0] partial;
    logic [32:0] trial;
    logic        fits;
    logic [31:0] rem_next;
    logic [31:0] quo_next;
    logic [31:0] quo_fixed;
    logic [31:0] rem_fixed;
    logic [31:0] div_final;

    logic        stallreq;
    logic        div_valid;
    logic [4:0]  shamt;
    logic [31:0] sra_res;
    logic [31:0] mul_low;
    logic [31:0] wdata;

    // Operand preparation for a new division: magnitudes for signed ops, raw values otherwise.
    assign is_div_op   = (ex.aluop_i == OP_DIV)  || (ex.aluop_i == OP_DIVU) ||
                         (ex.aluop_i == OP_REM)  || (ex.aluop_i == OP_REMU);
    assign div_req     = (ex.alusel_i == SEL_DIV) && is_div_op;
    assign signed_op   = (ex.aluop_i == OP_DIV) || (ex.aluop_i == OP_REM);
    assign want_rem    = (ex.aluop_i == OP_REM) || (ex.aluop_i == OP_REMU);
    assign a_neg       = signed_op && ex.reg1_i[31];
    assign b_neg       = signed_op && ex.reg2_i[31];
    assign a_abs       = a_neg ? (~ex.reg1_i + 32'd1) : ex.reg1_i;
    assign b_abs       = b_neg ? (~ex.reg2_i + 32'd1) : ex.reg2_i;
    assign div_by_zero = (ex.reg2_i == 32'd0);

    // One restoring step: shift in the next dividend bit and subtract when the divisor fits.
    assign partial   = {rem_q, quo_q[31]};
    assign trial     = partial - {1'b0, divisor_q};
    assign fits      = ~trial[32];
    assign rem_next  = fits ? trial[31:0] : partial[31:0];
    assign quo_next  = {quo_q[30:0], fits};
    assign quo_fixed = neg_quo_q ? (~quo_next + 32'd1) : quo_next;
    assign rem_fixed = neg_rem_q ? (~rem_next + 32'd1) : rem_next;
    assign div_final = want_rem_q ? rem_fixed : quo_fixed;

    always_ff @(posedge clk) begin
        if (!resetn) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        if (ex.flush_i) begin
            state_d = IDLE;
        end else begin
            case (state_q)
                IDLE: begin
                    if (div_req) begin
                        state_d = div_by_zero ? DONE : BUSY;
                    end
                end
                BUSY: begin
                    if (count_q == 5'd31) begin
                        state_d = DONE;
                    end
                end
                DONE:    state_d = IDLE;
                default: state_d = IDLE;
            endcase
        end
    end

    always_comb begin
        stallreq  = 1'b0;
        div_valid = 1'b0;
        if (!ex.flush_i) begin
            case (state_q)
                IDLE:    stallreq  = div_req;
                BUSY:    stallreq  = 1'b1;
                DONE:    div_valid = 1'b1;
                default: stallreq  = 1'b0;
            endcase
        end
    end

    // Divider datapath; a flush or reset abandons the iteration and nothing is written back.
    always_ff @(posedge clk) begin
        if (!resetn) begin
            count_q    <= 5'd0;
            divisor_q  <= 32'd0;
            quo_q      <= 32'd0;
            rem_q      <= 32'd0;
            result_q   <= 32'd0;
            want_rem_q <= 1'b0;
            neg_quo_q  <= 1'b0;
            neg_rem_q  <= 1'b0;
        end else if (ex.flush_i) begin
            count_q <= 5'd0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (div_req) begin
                        count_q    <= 5'd0;
                        divisor_q  <= b_abs;
                        quo_q      <= a_abs;
                        rem_q      <= 32'd0;
                        want_rem_q <= want_rem;
                        neg_quo_q  <= a_neg ^ b_neg;
                        neg_rem_q  <= a_neg;
                        if (div_by_zero) begin
                            result_q <= want_rem ? ex.reg1_i : 32'hFFFF_FFFF;
                        end
                    end
                end
                BUSY: begin
                    quo_q   <= quo_next;
                    rem_q   <= rem_next;
                    count_q <= count_q + 5'd1;
                    if (count_q == 5'd31) begin
                        result_q <= div_final;
                    end
                end
                default: count_q <= 5'd0;
            endcase
        end
    end

    assign shamt   = ex.reg1_i[4:0];
    assign sra_res = $unsigned($signed(ex.reg2_i) >>> shamt);
    assign mul_low = ex.reg1_i * ex.reg2_i;

    always_comb begin
        wdata = 32'd0;
        case (ex.alusel_i)
            SEL_LOGIC: begin
                case (ex.aluop_i)
                    OP_AND:  wdata = ex.reg1_i & ex.reg2_i;
                    OP_OR:   wdata = ex.reg1_i | ex.reg2_i;
                    OP_XOR:  wdata = ex.reg1_i ^ ex.reg2_i;
                    OP_NOR:  wdata = ~(ex.reg1_i | ex.reg2_i);
                    default: wdata = 32'd0;
                endcase
            end
            SEL_SHIFT: begin
                case (ex.aluop_i)
                    OP_SLL:  wdata = ex.reg2_i << shamt;
                    OP_SRL:  wdata = ex.reg2_i >> shamt;
                    OP_SRA:  wdata = sra_res;
                    default: wdata = 32'd0;
                endcase
            end
            SEL_ARITH: begin
                case (ex.aluop_i)
                    OP_ADD:  wdata = ex.reg1_i + ex.reg2_i;
                    OP_SUB:  wdata = ex.reg1_i - ex.reg2_i;
                    OP_SLT:  wdata = {31'd0, ($signed(ex.reg1_i) < $signed(ex.reg2_i))};
                    OP_SLTU: wdata = {31'd0, (ex.reg1_i < ex.reg2_i)};
                    default: wdata = 32'd0;
                endcase
            end
            SEL_MUL: begin
                if (ex.aluop_i == OP_MUL) begin
                    wdata = mul_low;
                end
            end
            SEL_DIV: begin
                if (div_valid && is_div_op) begin
                    wdata = result_q;
                end
            end
            SEL_NOP: wdata = 32'd0;
            default: wdata = 32'd0;
        endcase
    end

    assign ex.wd_o       = ex.wd_i;
    assign ex.wreg_o     = ex.wreg_i & ~stallreq;
    assign ex.wdata_o    = wdata;
    assign ex.stallreq_o = stallreq;

endmodule

// File: tb/tb_ex_unit.sv
// Bench for ex_unit: directed corner cases plus randomized single-cycle and divide traffic,
// compared against an arithmetic reference model.
module tb_ex_unit;

    localparam logic [2:0] SEL_NOP   = 3'b000;
    localparam logic [2:0] SEL_LOGIC = 3'b001;
    localparam logic [2:0] SEL_SHIFT = 3'b010;
    localparam logic [2:0] SEL_ARITH = 3'b011;
    localparam logic [2:0] SEL_MUL   = 3'b100;
    localparam logic [2:0] SEL_DIV   = 3'b101;

    localparam logic [7:0] OP_AND  = 8'h24;
    localparam logic [7:0] OP_OR   = 8'h25;
    localparam logic [7:0] OP_XOR  = 8'h26;
    localparam logic [7:0] OP_NOR  = 8'h27;
    localparam logic [7:0] OP_SLL  = 8'h7C;
    localparam logic [7:0] OP_SRL  = 8'h02;
    localparam logic [7:0] OP_SRA  = 8'h03;
    localparam logic [7:0] OP_ADD  = 8'h21;
    localparam logic [7:0] OP_SUB  = 8'h23;
    localparam logic [7:0] OP_SLT  = 8'h2A;
    localparam logic [7:0] OP_SLTU = 8'h2B;
    localparam logic [7:0] OP_MUL  = 8'h18;
    localparam logic [7:0] OP_DIV  = 8'h1A;
    localparam logic [7:0] OP_DIVU = 8'h1B;
    localparam logic [7:0] OP_REM  = 8'h1C;
    localparam logic [7:0] OP_REMU = 8'h1D;

    logic clk = 1'b0;
    logic resetn;
    int   check_cnt = 0;
    int   pass_cnt  = 0;

    always #5 clk = ~clk;

    ex_unit_if bus ();

    ex_unit dut (
        .clk    (clk),
        .resetn (resetn),
        .ex     (bus)
    );

    // Reference: results written straight from the instruction definitions.
    function automatic logic [31:0] modelAlu(input logic [2:0] sel, input logic [7:0] op,
                                             input logic [31:0] a, input logic [31:0] b);
        logic [63:0] prod;
        int n;
        n = int'(a[4:0]);
        prod = {32'd0, a} * {32'd0, b};
        case (sel)
            SEL_LOGIC:
                case (op)
                    OP_AND:  return a & b;
                    OP_OR:   return a | b;
                    OP_XOR:  return a ^ b;
                    OP_NOR:  return ~(a | b);
                    default: return 32'd0;
                endcase
            SEL_SHIFT:
                case (op)
                    OP_SLL:  return b << n;
                    OP_SRL:  return b >> n;
                    OP_SRA:  return (b >> n) | (b[31] ? ~(32'hFFFF_FFFF >> n) : 32'd0);
                    default: return 32'd0;
                endcase
            SEL_ARITH:
                case (op)
                    OP_ADD:  return a + b;
                    OP_SUB:  return a - b;
                    OP_SLT:  return ($signed(a) < $signed(b)) ? 32'd1 : 32'd0;
                    OP_SLTU: return (a < b) ? 32'd1 : 32'd0;
                    default: return 32'd0;
                endcase
            SEL_MUL:  return (op == OP_MUL) ? prod[31:0] : 32'd0;
            default:  return 32'd0;
        endcase
    endfunction

    function automatic logic [31:0] modelDiv(input logic [7:0] op, input logic [31:0] a,
                                             input logic [31:0] b);
        longint sa, sb, q, r;
        if (b == 32'd0) return (op == OP_DIV || op == OP_DIVU) ? 32'hFFFF_FFFF : a;
        if (op == OP_DIV || op == OP_REM) begin
            sa = longint'($signed(a));
            sb = longint'($signed(b));
        end else begin
            sa = longint'({32'd0, a});
            sb = longint'({32'd0, b});
        end
        q = sa / sb;
        r = sa % sb;
        return (op == OP_DIV || op == OP_DIVU) ? 32'(q) : 32'(r);
    endfunction

    task automatic checkOutput(input string tag, input logic [31:0] observed,
                               input logic [31:0] expected);
        check_cnt = check_cnt + 1;
        assert (observed === expected) pass_cnt = pass_cnt + 1;
        else $error("[TB] FAIL %s: observed %08h expected %08h", tag, observed, expected);
    endtask

    task automatic applyStimulus(input logic [2:0] sel, input logic [7:0] op,
                                 input logic [31:0] a, input logic [31:0] b,
                                 input logic [4:0] wd, input logic wreg);
        bus.alusel_i = sel;
        bus.aluop_i  = op;
        bus.reg1_i   = a;
        bus.reg2_i   = b;
        bus.wd_i     = wd;
        bus.wreg_i   = wreg;
    endtask

    task automatic nextCycle();
        @(posedge clk);
        #1;
    endtask

    task automatic sampleOutputs();
        @(negedge clk);
    endtask

    task automatic checkSingle(input string tag, input logic [2:0] sel, input logic [7:0] op,
                               input logic [31:0] a, input logic [31:0] b);
        applyStimulus(sel, op, a, b, 5'd3, 1'b1);
        sampleOutputs();
        checkOutput({tag, " wdata"}, bus.wdata_o, modelAlu(sel, op, a, b));
        checkOutput({tag, " stall"}, {31'd0, bus.stallreq_o}, 32'd0);
        nextCycle();
    endtask

    // Holds a division on the inputs, counts stall cycles, then checks the write-back cycle.
    task automatic runDiv(input string tag, input logic [7:0] op, input logic [31:0] a,
                          input logic [31:0] b, input bit scramble, input bit backToBack);
        int stalls;
        stalls = 0;
        applyStimulus(SEL_DIV, op, a, b, 5'd9, 1'b1);
        sampleOutputs();
        checkOutput({tag, " wreg while stalled"}, {31'd0, bus.wreg_o}, 32'd0);
        while (bus.stallreq_o === 1'b1 && stalls < 100) begin
            stalls = stalls + 1;
            nextCycle();
            if (scramble) begin
                bus.reg1_i = $urandom;
                bus.reg2_i = $urandom;
            end
            sampleOutputs();
        end
        checkOutput({tag, " stall cycles"}, 32'(stalls), (b == 32'd0) ? 32'd1 : 32'd33);
        checkOutput({tag, " result"}, bus.wdata_o, modelDiv(op, a, b));
        checkOutput({tag, " wreg at result"}, {31'd0, bus.wreg_o}, 32'd1);
        nextCycle();
        if (backToBack) begin
            sampleOutputs();
            checkOutput({tag, " restart after done"}, {31'd0, bus.stallreq_o}, 32'd1);
            bus.flush_i = 1'b1;
            nextCycle();
            bus.flush_i = 1'b0;
        end
        applyStimulus(SEL_NOP, 8'h00, 32'd0, 32'd0, 5'd0, 1'b0);
    endtask

    // Starts DIVU, lets it reach iteration 10, then aborts with flush or reset.
    task automatic abortDiv(input string tag, input bit useReset);
        logic [31:0] x, y;
        applyStimulus(SEL_DIV, OP_DIVU, $urandom, $urandom | 32'd1, 5'd4, 1'b1);
        for (int i = 0; i < 11; i++) nextCycle();
        sampleOutputs();
        checkOutput({tag, " busy at count 10"}, {31'd0, bus.stallreq_o}, 32'd1);
        if (useReset) begin
            resetn = 1'b0;
        end else begin
            bus.flush_i = 1'b1;
            #1;
            checkOutput({tag, " stall in flush cycle"}, {31'd0, bus.stallreq_o}, 32'd0);
        end
        nextCycle();
        resetn = 1'b1;
        bus.flush_i = 1'b0;
        x = $urandom;
        y = $urandom;
        applyStimulus(SEL_ARITH, OP_ADD, x, y, 5'd6, 1'b1);
        sampleOutputs();
        checkOutput({tag, " stall after abort"}, {31'd0, bus.stallreq_o}, 32'd0);
        checkOutput({tag, " add after abort"}, bus.wdata_o, x + y);
        checkOutput({tag, " wreg after abort"}, {31'd0, bus.wreg_o}, 32'd1);
        nextCycle();
        applyStimulus(SEL_NOP, 8'h00, 32'd0, 32'd0, 5'd0, 1'b0);
    endtask

    logic [10:0] opTab [16];
    logic [7:0]  divOps [4];

    initial begin
        opTab = '{{SEL_LOGIC, OP_AND}, {SEL_LOGIC, OP_OR},  {SEL_LOGIC, OP_XOR},
                  {SEL_LOGIC, OP_NOR}, {SEL_SHIFT, OP_SLL}, {SEL_SHIFT, OP_SRL},
                  {SEL_SHIFT, OP_SRA}, {SEL_ARITH, OP_ADD}, {SEL_ARITH, OP_SUB},
                  {SEL_ARITH, OP_SLT}, {SEL_ARITH, OP_SLTU}, {SEL_MUL, OP_MUL},
                  {SEL_LOGIC, OP_ADD}, {SEL_ARITH, OP_AND}, {SEL_NOP, OP_ADD},
                  {SEL_SHIFT, OP_MUL}};
        divOps = '{OP_DIV, OP_DIVU, OP_REM, OP_REMU};

        resetn = 1'b0;
        bus.flush_i = 1'b0;
        applyStimulus(SEL_NOP, 8'h00, 32'd0, 32'd0, 5'd0, 1'b0);
        nextCycle();
        nextCycle();
        resetn = 1'b1;
        sampleOutputs();
        checkOutput("reset wdata", bus.wdata_o, 32'd0);
        checkOutput("reset wreg", {31'd0, bus.wreg_o}, 32'd0);
        checkOutput("reset stall", {31'd0, bus.stallreq_o}, 32'd0);
        checkOutput("reset wd", {27'd0, bus.wd_o}, 32'd0);
        nextCycle();

        applyStimulus(SEL_ARITH, OP_ADD, 32'h7FFF_FFFF, 32'd1, 5'd17, 1'b1);
        sampleOutputs();
        checkOutput("add wrap", bus.wdata_o, 32'h8000_0000);
        checkOutput("add stall", {31'd0, bus.stallreq_o}, 32'd0);
        checkOutput("add wreg", {31'd0, bus.wreg_o}, 32'd1);
        checkOutput("add wd", {27'd0, bus.wd_o}, 32'd17);
        nextCycle();

        checkSingle("sra by 4", SEL_SHIFT, OP_SRA, 32'd4, 32'hF000_0000);
        checkSingle("sra by 0", SEL_SHIFT, OP_SRA, 32'd0, 32'h8765_4321);
        checkSingle("sltu", SEL_ARITH, OP_SLTU, 32'd1, 32'hFFFF_FFFF);
        checkSingle("slt", SEL_ARITH, OP_SLT, 32'hFFFF_FFFF, 32'd1);

        for (int i = 0; i < 40; i++) begin
            int k;
            k = $urandom_range(0, 15);
            checkSingle($sformatf("random op %0d", i), opTab[k][10:8], opTab[k][7:0],
                        $urandom, $urandom);
        end

        runDiv("div -7/2", OP_DIV, 32'hFFFF_FFF9, 32'd2, 1'b0, 1'b1);
        runDiv("rem -7/2", OP_REM, 32'hFFFF_FFF9, 32'd2, 1'b0, 1'b0);
        runDiv("divu 100/0", OP_DIVU, 32'd100, 32'd0, 1'b0, 1'b0);
        runDiv("remu 100/0", OP_REMU, 32'd100, 32'd0, 1'b0, 1'b0);
        runDiv("rem -5/0", OP_REM, 32'hFFFF_FFFB, 32'd0, 1'b0, 1'b0);
        runDiv("div overflow", OP_DIV, 32'h8000_0000, 32'hFFFF_FFFF, 1'b0, 1'b0);
        runDiv("rem overflow", OP_REM, 32'h8000_0000, 32'hFFFF_FFFF, 1'b0, 1'b0);
        for (int i = 0; i < 4; i++) begin
            runDiv($sformatf("random div %0d", i), divOps[$urandom_range(0, 3)],
                   $urandom, $urandom >> $urandom_range(0, 28), 1'b1, 1'b0);
        end

        abortDiv("flush", 1'b0);
        abortDiv("reset", 1'b1);

        $display("%0d/%0d checks passed", pass_cnt, check_cnt);
        $finish;
    end

    initial begin
        #200000;
        $display("[TB] FAIL watchdog: observed timeout expected completion");
        $fatal(1, "[TB] simulation did not complete");
    end

endmodule
